// File: rtl/fwd_sched_pkg.sv
// fwd_sched_pkg: shared types and constants for the EXE-stage forwarding scheduler.
package fwd_sched_pkg;
    localparam int REG_AW = 4;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              wb_en;
        logic              mem_r_en;
    } slot_t;
endpackage

// File: rtl/fwd_sched_if.sv
// fwd_sched_if: ID-stage request and hazard/select response bundle for fwd_sched.
interface fwd_sched_if #(parameter int CNT_W = 16);
    import fwd_sched_pkg::*;
    logic              Forward_EN;
    logic              freeze;
    logic              flush;
    logic              ID_Valid;
    logic [REG_AW-1:0] ID_Src1;
    logic [REG_AW-1:0] ID_Src2;
    logic              ID_Use_Src1;
    logic              ID_Two_Src;
    logic [REG_AW-1:0] ID_Dest;
    logic              ID_WB_EN;
    logic              ID_MEM_R_EN;
    logic              Hazard;
    logic [1:0]        Sel_src1;
    logic [1:0]        Sel_src2;
    logic [CNT_W-1:0]  Stall_Cnt;

    modport master (
        output Forward_EN, freeze, flush, ID_Valid, ID_Src1, ID_Src2, ID_Use_Src1,
               ID_Two_Src, ID_Dest, ID_WB_EN, ID_MEM_R_EN,
        input  Hazard, Sel_src1, Sel_src2, Stall_Cnt
    );
    modport slave (
        input  Forward_EN, freeze, flush, ID_Valid, ID_Src1, ID_Src2, ID_Use_Src1,
               ID_Two_Src, ID_Dest, ID_WB_EN, ID_MEM_R_EN,
        output Hazard, Sel_src1, Sel_src2, Stall_Cnt
    );
endinterface

// File: rtl/fwd_match.sv
// fwd_match: compares one ID source against the EXE and MEM scoreboard slots.
module fwd_match
    import fwd_sched_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  slot_t             e,
    input  slot_t             m,
    output logic              match_e,
    output logic              match_m,
    output logic              load
);
    assign match_e = use_src & e.valid & e.wb_en & (e.dest == src);
    assign match_m = use_src & m.valid & m.wb_en & (m.dest == src);
    assign load    = match_e & e.mem_r_en;
endmodule

// File: rtl/fwd_sched.sv
// fwd_sched: EXE operand forwarding selects, load-use/no-forward hazard detection and
// stall counting. The WB stage needs no slot: the register file writes through.
module fwd_sched
    import fwd_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst,
    fwd_sched_if.slave bus
);
    slot_t            e, m;
    logic [1:0]       sel1, sel2, nsel1, nsel2;
    logic [CNT_W-1:0] cnt;
    logic             me1, mm1, ld1, me2, mm2, ld2, hazard, kill;

    fwd_match u_src1 (
        .src(bus.ID_Src1), .use_src(bus.ID_Valid & bus.ID_Use_Src1), .e(e), .m(m),
        .match_e(me1), .match_m(mm1), .load(ld1)
    );
    fwd_match u_src2 (
        .src(bus.ID_Src2), .use_src(bus.ID_Valid & bus.ID_Two_Src), .e(e), .m(m),
        .match_e(me2), .match_m(mm2), .load(ld2)
    );

    always_comb begin
        hazard = ~bus.flush & (bus.Forward_EN ? (ld1 | ld2) : (me1 | mm1 | me2 | mm2));
        kill   = hazard | bus.flush | ~bus.ID_Valid;
        // newest producer (EXE) takes priority over MEM
        nsel1  = (kill | ~bus.Forward_EN) ? SEL_REG : me1 ? SEL_MEM : mm1 ? SEL_WB : SEL_REG;
        nsel2  = (kill | ~bus.Forward_EN) ? SEL_REG : me2 ? SEL_MEM : mm2 ? SEL_WB : SEL_REG;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e    <= '0;
            m    <= '0;
            sel1 <= SEL_REG;
            sel2 <= SEL_REG;
            cnt  <= '0;
        end else if (!bus.freeze) begin
            m    <= e;
            e    <= kill ? '0 : '{valid: 1'b1, dest: bus.ID_Dest, wb_en: bus.ID_WB_EN,
                                  mem_r_en: bus.ID_MEM_R_EN};
            sel1 <= nsel1;
            sel2 <= nsel2;
            if (hazard && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.Hazard    = hazard;
    assign bus.Sel_src1  = sel1;
    assign bus.Sel_src2  = sel2;
    assign bus.Stall_Cnt = cnt;
endmodule

// File: tb/tb_fwd_sched.sv
// tb_fwd_sched: directed pipeline sequences for fwd_sched with hand-computed expectations.
module tb_fwd_sched;
    import fwd_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    fwd_sched_if #(.CNT_W(16)) b ();
    fwd_sched #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(b));

    // ID fields are driven just after the falling edge and sampled 1 ns later
    task automatic id(input logic v, input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                      input logic u2, input logic [3:0] d, input logic wb, input logic mr);
        b.ID_Valid = v; b.ID_Src1 = s1; b.ID_Use_Src1 = u1; b.ID_Src2 = s2;
        b.ID_Two_Src = u2; b.ID_Dest = d; b.ID_WB_EN = wb; b.ID_MEM_R_EN = mr;
        #1;
    endtask

    task automatic nop;
        id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic do_reset;
        b.freeze = 1'b0; b.flush = 1'b0; b.Forward_EN = 1'b1;
        rst = 1'b0;
        cyc;
        nop;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL reset_hazard got %b exp 0", b.Hazard); end
        vecs++; if (b.Sel_src1 !== 2'b00) begin errs++; $display("FAIL reset_sel1 got %b exp 00", b.Sel_src1); end
        vecs++; if (b.Sel_src2 !== 2'b00) begin errs++; $display("FAIL reset_sel2 got %b exp 00", b.Sel_src2); end
        vecs++; if (b.Stall_Cnt !== 16'd0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", b.Stall_Cnt); end
    endtask

    task automatic test_fwd_mem;
        do_reset;
        cyc; id(1, 4'd8, 1, 4'd9, 1, 4'd1, 1, 0);
        cyc; id(1, 4'd1, 1, 4'd3, 1, 4'd2, 1, 0);
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL mem_hazard got %b exp 0", b.Hazard); end
        cyc; nop;
        vecs++; if (b.Sel_src1 !== SEL_MEM) begin errs++; $display("FAIL mem_sel1 got %b exp 01", b.Sel_src1); end
        vecs++; if (b.Sel_src2 !== SEL_REG) begin errs++; $display("FAIL mem_sel2 got %b exp 00", b.Sel_src2); end
    endtask

    task automatic test_fwd_wb;
        do_reset;
        cyc; id(1, 4'd8, 1, 4'd9, 1, 4'd1, 1, 0);
        cyc; nop;
        cyc; id(1, 4'd5, 1, 4'd1, 1, 4'd4, 1, 0);
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL wb_hazard got %b exp 0", b.Hazard); end
        cyc; nop;
        vecs++; if (b.Sel_src1 !== SEL_REG) begin errs++; $display("FAIL wb_sel1 got %b exp 00", b.Sel_src1); end
        vecs++; if (b.Sel_src2 !== SEL_WB) begin errs++; $display("FAIL wb_sel2 got %b exp 10", b.Sel_src2); end
    endtask

    task automatic test_priority;
        do_reset;
        cyc; id(1, 4'd8, 1, 4'd9, 1, 4'd1, 1, 0);
        cyc; id(1, 4'd8, 1, 4'd9, 1, 4'd1, 1, 0);
        cyc; id(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0);
        cyc; nop;
        vecs++; if (b.Sel_src1 !== SEL_MEM) begin errs++; $display("FAIL prio_sel1 got %b exp 01", b.Sel_src1); end
        vecs++; if (b.Sel_src2 !== SEL_MEM) begin errs++; $display("FAIL prio_sel2 got %b exp 01", b.Sel_src2); end
    endtask

    task automatic test_load_use;
        do_reset;
        cyc; id(1, 4'd8, 1, 4'd9, 0, 4'd6, 1, 1);
        cyc; id(1, 4'd6, 1, 4'd6, 1, 4'd7, 1, 0);
        vecs++; if (b.Hazard !== 1'b1) begin errs++; $display("FAIL lu_hazard got %b exp 1", b.Hazard); end
        cyc; #1;
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL lu_hazard_clear got %b exp 0", b.Hazard); end
        vecs++; if (b.Sel_src1 !== SEL_REG) begin errs++; $display("FAIL lu_bubble_sel1 got %b exp 00", b.Sel_src1); end
        vecs++; if (b.Stall_Cnt !== 16'd1) begin errs++; $display("FAIL lu_cnt got %0d exp 1", b.Stall_Cnt); end
        cyc; nop;
        vecs++; if (b.Sel_src1 !== SEL_WB) begin errs++; $display("FAIL lu_sel1 got %b exp 10", b.Sel_src1); end
        vecs++; if (b.Sel_src2 !== SEL_WB) begin errs++; $display("FAIL lu_sel2 got %b exp 10", b.Sel_src2); end
        vecs++; if (b.Stall_Cnt !== 16'd1) begin errs++; $display("FAIL lu_cnt_end got %0d exp 1", b.Stall_Cnt); end
    endtask

    task automatic test_no_forward;
        do_reset;
        b.Forward_EN = 1'b0;
        cyc; id(1, 4'd8, 1, 4'd9, 1, 4'd1, 1, 0);
        cyc; id(1, 4'd1, 1, 4'd3, 1, 4'd2, 1, 0);
        vecs++; if (b.Hazard !== 1'b1) begin errs++; $display("FAIL nf_hazard_e got %b exp 1", b.Hazard); end
        cyc; #1;
        vecs++; if (b.Hazard !== 1'b1) begin errs++; $display("FAIL nf_hazard_m got %b exp 1", b.Hazard); end
        cyc; #1;
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL nf_hazard_clear got %b exp 0", b.Hazard); end
        vecs++; if (b.Stall_Cnt !== 16'd2) begin errs++; $display("FAIL nf_cnt got %0d exp 2", b.Stall_Cnt); end
        cyc; nop;
        vecs++; if (b.Sel_src1 !== SEL_REG) begin errs++; $display("FAIL nf_sel1 got %b exp 00", b.Sel_src1); end
        cyc; id(1, 4'd8, 1, 4'd9, 1, 4'd1, 1, 0);
        cyc; nop;
        cyc; id(1, 4'd1, 1, 4'd3, 1, 4'd2, 1, 0);
        vecs++; if (b.Hazard !== 1'b1) begin errs++; $display("FAIL nf_m_only got %b exp 1", b.Hazard); end
        b.Forward_EN = 1'b1; #1;
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL nf_fe_switch got %b exp 0", b.Hazard); end
        b.Forward_EN = 1'b0; #1;
        cyc; #1;
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL nf_m_clear got %b exp 0", b.Hazard); end
        vecs++; if (b.Stall_Cnt !== 16'd3) begin errs++; $display("FAIL nf_cnt_m got %0d exp 3", b.Stall_Cnt); end
        b.Forward_EN = 1'b1;
    endtask

    task automatic test_freeze;
        do_reset;
        cyc; id(1, 4'd8, 1, 4'd9, 1, 4'd2, 1, 0);
        cyc; id(1, 4'd2, 1, 4'd0, 0, 4'd6, 1, 1);
        cyc; id(1, 4'd6, 1, 4'd6, 1, 4'd7, 1, 0);
        vecs++; if (b.Hazard !== 1'b1) begin errs++; $display("FAIL fz_hazard got %b exp 1", b.Hazard); end
        vecs++; if (b.Sel_src1 !== SEL_MEM) begin errs++; $display("FAIL fz_ldr_sel1 got %b exp 01", b.Sel_src1); end
        b.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc; #1;
            vecs++; if (b.Hazard !== 1'b1) begin errs++; $display("FAIL fz_hold_hazard[%0d] got %b exp 1", i, b.Hazard); end
            vecs++; if (b.Sel_src1 !== SEL_MEM) begin errs++; $display("FAIL fz_hold_sel1[%0d] got %b exp 01", i, b.Sel_src1); end
            vecs++; if (b.Stall_Cnt !== 16'd0) begin errs++; $display("FAIL fz_hold_cnt[%0d] got %0d exp 0", i, b.Stall_Cnt); end
        end
        b.freeze = 1'b0;
        cyc; #1;
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL fz_release_hazard got %b exp 0", b.Hazard); end
        vecs++; if (b.Stall_Cnt !== 16'd1) begin errs++; $display("FAIL fz_release_cnt got %0d exp 1", b.Stall_Cnt); end
        vecs++; if (b.Sel_src1 !== SEL_REG) begin errs++; $display("FAIL fz_bubble_sel1 got %b exp 00", b.Sel_src1); end
        cyc; nop;
        vecs++; if (b.Sel_src1 !== SEL_WB) begin errs++; $display("FAIL fz_sel1 got %b exp 10", b.Sel_src1); end
        vecs++; if (b.Sel_src2 !== SEL_WB) begin errs++; $display("FAIL fz_sel2 got %b exp 10", b.Sel_src2); end
    endtask

    // continues from test_freeze so the stall counter starts at 1
    task automatic test_flush_reset;
        cyc; nop;
        cyc; nop;
        cyc; id(1, 4'd8, 1, 4'd0, 0, 4'd6, 1, 1);
        cyc; id(1, 4'd6, 1, 4'd6, 1, 4'd7, 1, 0);
        b.flush = 1'b1; #1;
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL fl_hazard got %b exp 0", b.Hazard); end
        cyc;
        b.flush = 1'b0; b.Forward_EN = 1'b0;
        id(1, 4'd7, 1, 4'd0, 0, 4'd9, 1, 0);
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL fl_e_bubble got %b exp 0", b.Hazard); end
        vecs++; if (b.Stall_Cnt !== 16'd1) begin errs++; $display("FAIL fl_cnt got %0d exp 1", b.Stall_Cnt); end
        vecs++; if (b.Sel_src1 !== SEL_REG) begin errs++; $display("FAIL fl_sel1 got %b exp 00", b.Sel_src1); end
        b.Forward_EN = 1'b1;
        id(1, 4'd6, 1, 4'd0, 0, 4'd10, 1, 0);
        cyc; #1;
        vecs++; if (b.Sel_src1 !== SEL_WB) begin errs++; $display("FAIL pre_rst_sel1 got %b exp 10", b.Sel_src1); end
        b.Forward_EN = 1'b0;
        id(1, 4'd10, 1, 4'd0, 0, 4'd11, 1, 0);
        vecs++; if (b.Hazard !== 1'b1) begin errs++; $display("FAIL pre_rst_hazard got %b exp 1", b.Hazard); end
        rst = 1'b0; #1;
        vecs++; if (b.Hazard !== 1'b0) begin errs++; $display("FAIL rst_mid_hazard got %b exp 0", b.Hazard); end
        vecs++; if (b.Sel_src1 !== SEL_REG) begin errs++; $display("FAIL rst_mid_sel1 got %b exp 00", b.Sel_src1); end
        vecs++; if (b.Sel_src2 !== SEL_REG) begin errs++; $display("FAIL rst_mid_sel2 got %b exp 00", b.Sel_src2); end
        vecs++; if (b.Stall_Cnt !== 16'd0) begin errs++; $display("FAIL rst_mid_cnt got %0d exp 0", b.Stall_Cnt); end
        rst = 1'b1;
    endtask

    initial begin
        test_reset;
        test_fwd_mem;
        test_fwd_wb;
        test_priority;
        test_load_use;
        test_no_forward;
        test_freeze;
        test_flush_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
